// File: rtl/ppg_pkg.sv
// Shared types and default tuning for the PPG LED calibration controller.
// Optional feature macro: PPG_CAL_TIMEOUT_EN (adds the ERROR state and window limit).
package ppg_pkg;

    // Default configuration; the controller parameters fall back to these.
    localparam int PPG_NUM_CH   = 2;
    localparam int PPG_ADC_W    = 8;
    localparam int PPG_DC_W     = 7;
    localparam int PPG_PGA_W    = 4;
    localparam int PPG_WIN      = 27;
    localparam int PPG_SETTLE   = 2;
    localparam int PPG_DC_LO    = 110;
    localparam int PPG_DC_HI    = 145;
    localparam int PPG_CLIP_LO  = 10;
    localparam int PPG_CLIP_HI  = 245;
    localparam int PPG_DWELL    = 10;
    localparam int PPG_MAX_ITER = 64;

    typedef enum logic [2:0] {
        IDLE,
        DC_CAL,
        PGA_CAL,
        OPERATE
`ifdef PPG_CAL_TIMEOUT_EN
        , ERROR
`endif
    } ppg_state_e;

endpackage

// File: rtl/ppg_cal_controller_if.sv
// Per-channel sample stream produced by the PPG calibration controller.
// Optional feature macro: PPG_CAL_TIMEOUT_EN (no effect on this interface).
interface ppg_cal_controller_if
    import ppg_pkg::*;
#(
    parameter int NUM_CH = PPG_NUM_CH,
    parameter int ADC_W  = PPG_ADC_W
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic             Ch_valid;
    logic [CH_W-1:0]  Ch_id;
    logic [ADC_W-1:0] ADC_Value;

    modport master (output Ch_valid, Ch_id, ADC_Value);
    modport slave  (input  Ch_valid, Ch_id, ADC_Value);
endinterface

// File: rtl/ppg_win_stats.sv
// Measurement window: drop SETTLE samples, then gather sum/min/max over WIN
// samples; done is high for the single decision cycle that follows.
// Optional feature macro: PPG_CAL_TIMEOUT_EN (no effect on this module).
module ppg_win_stats
    import ppg_pkg::*;
#(
    parameter int ADC_W  = PPG_ADC_W,
    parameter int WIN    = PPG_WIN,
    parameter int SETTLE = PPG_SETTLE,
    parameter int SUM_W  = ADC_W + $clog2(WIN + 1)
) (
    input  logic             CLK,
    input  logic             rst_n,
    input  logic             run,
    input  logic             restart,
    input  logic [ADC_W-1:0] sample,
    output logic             done,
    output logic [SUM_W-1:0] sum,
    output logic [ADC_W-1:0] min_val,
    output logic [ADC_W-1:0] max_val
);
    localparam int LAST  = SETTLE + WIN;
    localparam int CNT_W = $clog2(LAST + 1);
    localparam logic [CNT_W-1:0] CNT_FIRST = CNT_W'(SETTLE);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(LAST);

    logic [CNT_W-1:0] cnt;

    // Sample counter and running statistics; the first kept sample seeds all three.
    always_ff @(posedge CLK or negedge rst_n) begin
        // NOTE: non-blocking assignments so every register sees pre-edge values.
        if (!rst_n) begin
            cnt     <= '0;
            sum     <= '0;
            min_val <= '0;
            max_val <= '0;
        end else if (restart || !run) begin
            cnt <= '0;
        end else begin
            cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
            if (cnt == CNT_FIRST) begin
                sum     <= SUM_W'(sample);
                min_val <= sample;
                max_val <= sample;
            end else if (cnt > CNT_FIRST && cnt < CNT_LAST) begin
                sum <= sum + SUM_W'(sample);
                if (sample < min_val) min_val <= sample;
                if (sample > max_val) max_val <= sample;
            end
        end
    end

    assign done = run && (cnt == CNT_LAST);

endmodule

// File: rtl/ppg_cal_controller.sv
// PPG LED calibration controller: per channel, servo the DC-compensation code
// into the target band, then raise PGA gain until just below clipping; then
// multiplex the channels with their stored codes and emit one sample per visit.
// Optional feature macro: PPG_CAL_TIMEOUT_EN (window limit and ERROR state).
module ppg_cal_controller
    import ppg_pkg::*;
#(
    parameter int NUM_CH   = PPG_NUM_CH,
    parameter int ADC_W    = PPG_ADC_W,
    parameter int DC_W     = PPG_DC_W,
    parameter int PGA_W    = PPG_PGA_W,
    parameter int WIN      = PPG_WIN,
    parameter int SETTLE   = PPG_SETTLE,
    parameter int DC_LO    = PPG_DC_LO,
    parameter int DC_HI    = PPG_DC_HI,
    parameter int CLIP_LO  = PPG_CLIP_LO,
    parameter int CLIP_HI  = PPG_CLIP_HI,
    parameter int DWELL    = PPG_DWELL,
    parameter int MAX_ITER = PPG_MAX_ITER
) (
    input  logic              CLK,
    input  logic              rst_n,
    input  logic              Find_setting,
    input  logic [ADC_W-1:0]  ADC,
    output logic [NUM_CH-1:0] LED_EN,
    output logic [DC_W-1:0]   DC_Comp,
    output logic [PGA_W-1:0]  PGA_Gain,
    output logic              CLK_Filter,
    output logic              Busy,
    output logic              Done,
    output logic              Cal_err,
    ppg_cal_controller_if.master ch_bus
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int DW_W  = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int SUM_W = ADC_W + $clog2(WIN + 1);
    localparam logic [CH_W-1:0]  CH_LAST    = CH_W'(NUM_CH - 1);
    localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL - 1);
    localparam logic [DC_W-1:0]  DC_MAX     = '1;
    localparam logic [PGA_W-1:0] PGA_MAX    = '1;

    ppg_state_e        state_q, state_n;
    logic [CH_W-1:0]   ch_q, ch_n, ch_next;
    logic [DW_W-1:0]   dwell_q, dwell_n;
    logic [DC_W-1:0]   dc_q, dc_n;
    logic [PGA_W-1:0]  pga_q, pga_n, pga_store;
    logic [NUM_CH-1:0] led_q, led_n;
    logic [DC_W-1:0]   dc_tab_q  [NUM_CH];
    logic [DC_W-1:0]   dc_tab_n  [NUM_CH];
    logic [PGA_W-1:0]  pga_tab_q [NUM_CH];
    logic [PGA_W-1:0]  pga_tab_n [NUM_CH];
    logic              valid_q, valid_n;
    logic [CH_W-1:0]   id_q, id_n;
    logic [ADC_W-1:0]  val_q, val_n;
    logic              busy_q, busy_n;
    logic              done_q, done_n;
    logic              dc_accept, pga_done, sat;
    logic              clk_div_q;

    logic              win_run, win_done;
    logic [SUM_W-1:0]  stat_sum, avg;
    logic [ADC_W-1:0]  stat_min, stat_max;
    logic              clip;

`ifdef PPG_CAL_TIMEOUT_EN
    localparam int ITER_W = (MAX_ITER > 1) ? $clog2(MAX_ITER) : 1;
    localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(MAX_ITER - 1);
    logic              err_q, err_n;
    logic [ITER_W-1:0] iter_q, iter_n;
`endif

    assign win_run = (state_q == DC_CAL) || (state_q == PGA_CAL);

    ppg_win_stats #(
        .ADC_W  (ADC_W),
        .WIN    (WIN),
        .SETTLE (SETTLE),
        .SUM_W  (SUM_W)
    ) u_win_stats (
        .CLK     (CLK),
        .rst_n   (rst_n),
        .run     (win_run),
        .restart (Find_setting),
        .sample  (ADC),
        .done    (win_done),
        .sum     (stat_sum),
        .min_val (stat_min),
        .max_val (stat_max)
    );

    assign avg  = stat_sum / SUM_W'(WIN);
    assign clip = (stat_min <= ADC_W'(CLIP_LO)) || (stat_max >= ADC_W'(CLIP_HI));
    assign ch_next = (ch_q == CH_LAST) ? '0 : ch_q + 1'b1;

    // Next-state and next-output decisions; Find_setting overrides everything last.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_n   = state_q;
        ch_n      = ch_q;
        dwell_n   = dwell_q;
        dc_n      = dc_q;
        pga_n     = pga_q;
        led_n     = led_q;
        dc_tab_n  = dc_tab_q;
        pga_tab_n = pga_tab_q;
        valid_n   = 1'b0;
        id_n      = id_q;
        val_n     = val_q;
        busy_n    = busy_q;
        done_n    = done_q;
        dc_accept = 1'b0;
        pga_done  = 1'b0;
        sat       = 1'b0;
        pga_store = '0;
`ifdef PPG_CAL_TIMEOUT_EN
        err_n     = err_q;
        iter_n    = iter_q;
`endif
        case (state_q)
            IDLE: led_n = '0;
            DC_CAL: if (win_done) begin
                if (avg < SUM_W'(DC_LO)) begin
                    if (dc_q == '0) sat = 1'b1;
                    else            dc_n = dc_q - 1'b1;
                end else if (avg > SUM_W'(DC_HI)) begin
                    if (dc_q == DC_MAX) sat = 1'b1;
                    else                dc_n = dc_q + 1'b1;
                end else begin
                    dc_accept = 1'b1;
                end
`ifndef PPG_CAL_TIMEOUT_EN
                // Without a fault path, a pinned code is the best available setting.
                if (sat) dc_accept = 1'b1;
`endif
                if (dc_accept) begin
                    dc_tab_n[ch_q] = dc_q;
                    state_n        = PGA_CAL;
                    pga_n          = '0;
                end
            end
            PGA_CAL: if (win_done) begin
                if (clip) begin
                    pga_done  = 1'b1;
                    pga_store = (pga_q == '0) ? '0 : pga_q - 1'b1;
                end else if (pga_q != PGA_MAX) begin
                    pga_n = pga_q + 1'b1;
                end else begin
                    pga_done  = 1'b1;
                    pga_store = PGA_MAX;
                end
                if (pga_done) begin
                    pga_tab_n[ch_q] = pga_store;
                    ch_n            = ch_next;
                    led_n           = NUM_CH'(1) << ch_next;
                    if (ch_q == CH_LAST) begin
                        state_n = OPERATE;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        dwell_n = '0;
                        dc_n    = dc_tab_n[ch_next];
                        pga_n   = pga_tab_n[ch_next];
                    end else begin
                        state_n = DC_CAL;
                        dc_n    = '0;
                        pga_n   = '0;
                    end
                end
            end
            OPERATE: if (dwell_q == DWELL_LAST) begin
                valid_n = 1'b1;
                id_n    = ch_q;
                val_n   = ADC;
                dwell_n = '0;
                ch_n    = ch_next;
                led_n   = NUM_CH'(1) << ch_next;
                dc_n    = dc_tab_q[ch_next];
                pga_n   = pga_tab_q[ch_next];
            end else begin
                dwell_n = dwell_q + 1'b1;
            end
`ifdef PPG_CAL_TIMEOUT_EN
            ERROR: begin
                led_n  = '0;
                busy_n = 1'b0;
                done_n = 1'b0;
                err_n  = 1'b1;
            end
`endif
            default: state_n = IDLE;
        endcase
`ifdef PPG_CAL_TIMEOUT_EN
        // Each unresolved window counts against the phase; a saturated miss gives up at once.
        if (win_done && win_run) begin
            if (dc_accept || pga_done) begin
                iter_n = '0;
            end else if (sat || iter_q == ITER_LAST) begin
                state_n = ERROR;
                led_n   = '0;
                busy_n  = 1'b0;
                err_n   = 1'b1;
            end else begin
                iter_n = iter_q + 1'b1;
            end
        end
`endif
        if (Find_setting) begin
            state_n = DC_CAL;
            ch_n    = '0;
            dwell_n = '0;
            dc_n    = '0;
            pga_n   = '0;
            led_n   = NUM_CH'(1);
            valid_n = 1'b0;
            busy_n  = 1'b1;
            done_n  = 1'b0;
`ifdef PPG_CAL_TIMEOUT_EN
            err_n   = 1'b0;
            iter_n  = '0;
`endif
        end
    end

    // State, applied codes, calibration tables and the sample stream register.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ch_q      <= '0;
            dwell_q   <= '0;
            dc_q      <= '0;
            pga_q     <= '0;
            led_q     <= '0;
            // NOTE: the tables are small flop arrays and must read zero out of reset.
            dc_tab_q  <= '{default: '0};
            pga_tab_q <= '{default: '0};
            valid_q   <= 1'b0;
            id_q      <= '0;
            val_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef PPG_CAL_TIMEOUT_EN
            err_q     <= 1'b0;
            iter_q    <= '0;
`endif
        end else begin
            state_q   <= state_n;
            ch_q      <= ch_n;
            dwell_q   <= dwell_n;
            dc_q      <= dc_n;
            pga_q     <= pga_n;
            led_q     <= led_n;
            dc_tab_q  <= dc_tab_n;
            pga_tab_q <= pga_tab_n;
            valid_q   <= valid_n;
            id_q      <= id_n;
            val_q     <= val_n;
            busy_q    <= busy_n;
            done_q    <= done_n;
`ifdef PPG_CAL_TIMEOUT_EN
            err_q     <= err_n;
            iter_q    <= iter_n;
`endif
        end
    end

    // Filter clock: CLK divided by two.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) clk_div_q <= 1'b0;
        else        clk_div_q <= ~clk_div_q;
    end

    assign LED_EN           = led_q;
    assign DC_Comp          = dc_q;
    assign PGA_Gain         = pga_q;
    assign CLK_Filter       = clk_div_q;
    assign Busy             = busy_q;
    assign Done             = done_q;
    assign ch_bus.Ch_valid  = valid_q;
    assign ch_bus.Ch_id     = id_q;
    assign ch_bus.ADC_Value = val_q;
`ifdef PPG_CAL_TIMEOUT_EN
    assign Cal_err          = err_q;
`else
    assign Cal_err          = 1'b0;
`endif

endmodule

// File: tb/tb_ppg_cal_controller.sv
// Directed bench for ppg_cal_controller with a small ADC plant model that
// reacts to the applied LED/DC/PGA codes.
// Optional feature macro: PPG_CAL_TIMEOUT_EN (enables the timeout/error steps).
module tb_ppg_cal_controller;

    logic       CLK = 1'b0;
    logic       rst_n;
    logic       Find_setting;
    logic [7:0] ADC;
    logic [1:0] LED_EN;
    logic [6:0] DC_Comp;
    logic [3:0] PGA_Gain;
    logic       CLK_Filter;
    logic       Busy;
    logic       Done;
    logic       Cal_err;

    ppg_cal_controller_if #(.NUM_CH(2), .ADC_W(8)) ch_bus ();

    ppg_cal_controller dut (
        .CLK          (CLK),
        .rst_n        (rst_n),
        .Find_setting (Find_setting),
        .ADC          (ADC),
        .LED_EN       (LED_EN),
        .DC_Comp      (DC_Comp),
        .PGA_Gain     (PGA_Gain),
        .CLK_Filter   (CLK_Filter),
        .Busy         (Busy),
        .Done         (Done),
        .Cal_err      (Cal_err),
        .ch_bus       (ch_bus)
    );

    always #5 CLK = ~CLK;

    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    int         mode  = 0;
    int         adc_const = 128;
    logic [7:0] prev_adc = '0;

    // Plant: mode 0 constant; mode 1 DC-dependent level at gain 0, otherwise a
    // square swing around 128 scaled by gain; mode 2 oscillates between 150 and 100.
    function automatic logic [7:0] plant();
        int v;
        int base;
        int amp;
        base = 160;
        amp  = 20;
        if (LED_EN == 2'b10) begin
            base = 190;
            amp  = 15;
        end
        case (mode)
            1: begin
                if (PGA_Gain == 4'd0)  v = base - 5 * int'(DC_Comp);
                else if (cyc % 2 == 1) v = 128 + amp * int'(PGA_Gain);
                else                   v = 128 - amp * int'(PGA_Gain);
            end
            2:       v = DC_Comp[0] ? 100 : 150;
            default: v = adc_const;
        endcase
        if (v < 0)   v = 0;
        if (v > 255) v = 255;
        return 8'(v);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
        cyc++;
        prev_adc = ADC;
        ADC = plant();
    endtask

    task automatic goto(input int target);
        while (cyc < target) tick();
    endtask

    task automatic pulse_find();
        Find_setting = 1'b1;
        tick();
        Find_setting = 1'b0;
        cyc = 0;
    endtask

    initial begin
        rst_n        = 1'b0;
        Find_setting = 1'b0;
        ADC          = 8'd128;
        repeat (3) @(negedge CLK);

        // Reset state
        check("rst_led",     LED_EN, 0);
        check("rst_dc",      DC_Comp, 0);
        check("rst_pga",     PGA_Gain, 0);
        check("rst_clkf",    CLK_Filter, 0);
        check("rst_busy",    Busy, 0);
        check("rst_done",    Done, 0);
        check("rst_err",     Cal_err, 0);
        check("rst_valid",   ch_bus.Ch_valid, 0);
        check("rst_id",      ch_bus.Ch_id, 0);
        check("rst_value",   ch_bus.ADC_Value, 0);

        rst_n = 1'b1;
        repeat (5) tick();
        check("idle_busy",   Busy, 0);
        check("idle_led",    LED_EN, 0);
        check("clkf_odd",    CLK_Filter, 1);
        tick();
        check("clkf_even",   CLK_Filter, 0);

        // Constant 128: DC accepted at code 0, PGA climbs to 15 on both channels
        mode = 0;
        adc_const = 128;
        pulse_find();
        check("c128_busy",   Busy, 1);
        check("c128_led0",   LED_EN, 1);
        check("c128_dc0",    DC_Comp, 0);
        check("c128_done0",  Done, 0);
        goto(59);
        check("c128_pga_c59", PGA_Gain, 0);
        goto(60);
        check("c128_pga_c60", PGA_Gain, 1);
        goto(509);
        check("c128_pga15",  PGA_Gain, 15);
        check("c128_led_c509", LED_EN, 1);
        goto(510);
        check("c128_led1",   LED_EN, 2);
        check("c128_pga_ch1", PGA_Gain, 0);
        goto(1019);
        check("c128_busy_c1019", Busy, 1);
        goto(1020);
        check("c128_done",   Done, 1);
        check("c128_busy_op", Busy, 0);
        check("c128_op_led", LED_EN, 1);
        check("c128_op_pga", PGA_Gain, 15);
        check("c128_op_err", Cal_err, 0);

        // Low constant: DC code pinned at 0 and out of band
        adc_const = 50;
        pulse_find();
        goto(30);
`ifdef PPG_CAL_TIMEOUT_EN
        check("sat_err",     Cal_err, 1);
        check("sat_led",     LED_EN, 0);
        check("sat_busy",    Busy, 0);
        goto(60);
        check("sat_err_hold", Cal_err, 1);
`else
        check("sat_dc",      DC_Comp, 0);
        check("sat_busy",    Busy, 1);
        goto(60);
        check("sat_pga",     PGA_Gain, 1);
`endif

        // Reset in the middle of calibration
        goto(75);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", Busy, 0);
        check("midrst_led",  LED_EN, 0);
        check("midrst_pga",  PGA_Gain, 0);
        check("midrst_clkf", CLK_Filter, 0);
        @(negedge CLK);
        rst_n = 1'b1;
        repeat (40) tick();
        check("midrst_idle_busy", Busy, 0);
        check("midrst_idle_led",  LED_EN, 0);
        check("midrst_idle_done", Done, 0);

        // Plant-driven calibration: dc 3/9, pga 5/7
        mode = 1;
        pulse_find();
        goto(30);
        check("dc_inc",      DC_Comp, 1);
        goto(150);
        check("dc_edge_acc", DC_Comp, 3);
        check("pga_step1",   PGA_Gain, 1);
        goto(329);
        check("pga_clip_g6", PGA_Gain, 6);
        goto(330);
        check("ch1_led",     LED_EN, 2);
        check("ch1_dc0",     DC_Comp, 0);
        check("ch1_pga0",    PGA_Gain, 0);
        goto(629);
        check("ch1_dc9",     DC_Comp, 9);
        goto(899);
        check("ch1_pga8",    PGA_Gain, 8);
        goto(900);
        check("op_done",     Done, 1);
        check("op_led0",     LED_EN, 1);
        check("op_dc0",      DC_Comp, 3);
        check("op_pga0",     PGA_Gain, 5);

        // Operation: round-robin visits of 10 cycles
        goto(909);
        check("op_led_c909", LED_EN, 1);
        check("op_valid_c909", ch_bus.Ch_valid, 0);
        goto(910);
        check("op_led1",     LED_EN, 2);
        check("op_dc1",      DC_Comp, 9);
        check("op_pga1",     PGA_Gain, 7);
        check("op_valid0",   ch_bus.Ch_valid, 1);
        check("op_id0",      ch_bus.Ch_id, 0);
        check("op_val0",     ch_bus.ADC_Value, 228);
        goto(911);
        check("op_valid_pulse", ch_bus.Ch_valid, 0);
        goto(920);
        check("op_led_back", LED_EN, 1);
        check("op_dc_back",  DC_Comp, 3);
        check("op_pga_back", PGA_Gain, 5);
        check("op_valid1",   ch_bus.Ch_valid, 1);
        check("op_id1",      ch_bus.Ch_id, 1);
        check("op_val1",     ch_bus.ADC_Value, 233);

        // Restart from operation, then again during channel 1 PGA calibration
        pulse_find();
        check("rerun_done",  Done, 0);
        check("rerun_busy",  Busy, 1);
        goto(700);
        check("rerun_led1",  LED_EN, 2);
        check("rerun_pga2",  PGA_Gain, 2);
        pulse_find();
        check("restart_led", LED_EN, 1);
        check("restart_dc",  DC_Comp, 0);
        check("restart_pga", PGA_Gain, 0);
        check("restart_done", Done, 0);
        check("restart_busy", Busy, 1);
        goto(30);
        check("restart_dc_inc", DC_Comp, 1);

`ifdef PPG_CAL_TIMEOUT_EN
        // Oscillating average never settles: error after 64 windows
        mode = 2;
        pulse_find();
        goto(1919);
        check("tmo_err_c1919", Cal_err, 0);
        check("tmo_led_c1919", LED_EN, 1);
        goto(1920);
        check("tmo_err",     Cal_err, 1);
        check("tmo_led",     LED_EN, 0);
        check("tmo_busy",    Busy, 0);
        check("tmo_done",    Done, 0);
        pulse_find();
        check("tmo_clear",   Cal_err, 0);
        check("tmo_busy_again", Busy, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ppg_cal_controller.md
PPG_CAL_CONTROLLER -- requirements
Module: ppg_cal_controller

Interface
REQ-001 Parameter NUM_CH, default 2: number of LED channels calibrated and multiplexed.
REQ-002 Parameter ADC_W, default 8: ADC sample width.
REQ-003 Parameter DC_W, default 7, and PGA_W, default 4: DC-compensation and PGA-gain code widths.
REQ-004 Parameter WIN, default 27: samples per measurement window.
REQ-005 Parameter SETTLE, default 2: samples discarded after any code or LED change.
REQ-006 Parameters DC_LO, default 110, and DC_HI, default 145: inclusive target band for the window average.
REQ-007 Parameters CLIP_LO, default 10, and CLIP_HI, default 245: clipping thresholds.
REQ-008 Parameter DWELL, default 10: cycles per channel in operation.
REQ-009 Parameter MAX_ITER, default 64: window limit per calibration phase (only with the macro defined).
REQ-010 Clocking and reset are fixed: one clock; reset is asynchronous and active-low.
REQ-011 Ports: CLK  in  1  system clock.
REQ-012 Ports: rst_n  in  1  asynchronous active-low reset.
REQ-013 Ports: Find_setting  in  1  one-cycle calibration start/restart pulse.
REQ-014 Ports: ADC  in  ADC_W  sample, valid every cycle.
REQ-015 Ports: LED_EN  out  NUM_CH  one-hot or zero LED drive.
REQ-016 Ports: DC_Comp  out  DC_W  and PGA_Gain  out  PGA_W  applied codes.
REQ-017 Ports: CLK_Filter  out  1  CLK divided by 2.
REQ-018 Ports: Busy  out  1  calibrating; Done  out  1  operating.
REQ-019 Ports: Ch_valid  out  1  one-cycle pulse; Ch_id  out  $clog2(NUM_CH)  channel; ADC_Value  out  ADC_W  captured sample.
REQ-020 Ports: Cal_err  out  1  calibration failure.

Function
REQ-021 The FSM SHALL have the states IDLE, DC_CAL, PGA_CAL, OPERATE and, with the macro, ERROR; a channel index ch SHALL run 0..NUM_CH-1.
REQ-022 Find_setting SHALL, in any state, enter DC_CAL with ch=0, DC_Comp=0, PGA_Gain=0, Done=0, Cal_err=0 and Busy=1 on the next edge; it overrides all other transitions.
REQ-023 In DC_CAL and PGA_CAL, LED_EN SHALL equal 1<<ch.
REQ-024 A window SHALL discard SETTLE samples, then accumulate WIN samples, computing sum, min and max.
REQ-025 The decision SHALL be registered on the cycle after the last sample; the next window starts on the following cycle.
REQ-026 The DC_CAL average SHALL be floor(sum/WIN); the sum width SHALL be ADC_W+$clog2(WIN+1) with no overflow.
REQ-027 DC_CAL: average<DC_LO SHALL decrement DC_Comp; average>DC_HI SHALL increment it; in band SHALL store DC_Comp to dc_tab[ch] and enter PGA_CAL with PGA_Gain=0.
REQ-028 DC_Comp SHALL saturate at 0 and 2^DC_W-1 without wrap; saturated and out of band SHALL store and proceed (macro absent).
REQ-029 PGA_CAL: min>CLIP_LO and max<CLIP_HI and gain below maximum SHALL increment PGA_Gain and start a new window.
REQ-030 PGA_CAL on clip SHALL store max(PGA_Gain-1,0) to pga_tab[ch]; at maximum gain with no clip, it SHALL store the maximum.
REQ-031 After the PGA_CAL store, the next ch SHALL enter DC_CAL with DC_Comp=0, or after the last ch the FSM SHALL enter OPERATE with Busy=0 and Done=1.
REQ-032 OPERATE SHALL visit channels round-robin for DWELL cycles each.
REQ-033 On the first OPERATE cycle of a visit, LED_EN, DC_Comp and PGA_Gain SHALL take 1<<ch, dc_tab[ch] and pga_tab[ch].
REQ-034 On the last cycle of a visit, ADC_Value<=ADC, Ch_id<=ch and Ch_valid SHALL pulse for 1 cycle.
REQ-035 CLK_Filter SHALL toggle every CLK rising edge.
REQ-036 IDLE SHALL hold LED_EN=0 and wait for Find_setting.

Reset
REQ-037 While rst_n=0, all outputs, tables, counters and CLK_Filter SHALL be 0, and the state SHALL be IDLE.
REQ-038 Reset mid-calibration SHALL discard partial results; the block SHALL not self-start after reset.

Configuration
REQ-039 With PPG_CAL_TIMEOUT_EN defined, more than MAX_ITER windows in one phase, or saturated-and-out-of-band, SHALL enter ERROR.
REQ-040 In ERROR, LED_EN=0, Busy=0, Done=0 and Cal_err=1 until Find_setting or reset.
REQ-041 With PPG_CAL_TIMEOUT_EN undefined, there SHALL be no iteration counter or ERROR state, and Cal_err SHALL be tied to 0.

Structure
REQ-042 Package ppg_pkg SHALL hold the state enum and default thresholds.
REQ-043 Sub-module ppg_win_stats SHALL perform the settle/accumulate/min/max window and emit a one-cycle done pulse.

Verification
REQ-044 ADC=128 constant, Find_setting -> DC accepted at code 0 after 29 sample cycles, PGA reaches 15 with pga_tab=15, Done=1.
REQ-045 ADC=160-5*DC_Comp -> dc_tab[0]=3 (average 145, band edge accepted).
REQ-046 ADC swing 128±20*PGA_Gain -> clip at gain 6, pga_tab=5.
REQ-047 Tables {dc 3/9, pga 5/7} in OPERATE -> LED_EN 01/10 alternating every 10 cycles, codes switch with LED_EN, Ch_valid on each 10th cycle, Ch_id 0/1.
REQ-048 Find_setting during ch1 PGA_CAL -> next cycle DC_CAL ch0, Done=0, DC_Comp=0.
REQ-049 Macro on, window average alternating 100/150 -> Cal_err=1 after 64 windows, LED_EN=0.
